// File: rtl/sram_controller_if.sv
// System bus interface shared by the address decoder (master side) and
// memory-mapped slaves such as sram_controller.
interface Bus_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] data_wr;
  logic [3:0]  mask;
  logic        stall;
  logic [31:0] data_rd;
  logic [31:0] data_rd_2;

  modport master (
    output address, read, write, data_wr, mask,
    input  stall, data_rd, data_rd_2
  );

  modport slave (
    input  address, read, write, data_wr, mask,
    output stall, data_rd, data_rd_2
  );
endinterface

// File: rtl/sram_controller.sv
// Bus slave that sequences multi-cycle accesses to a 32-bit asynchronous SRAM.
// Optional SRAM_DUAL_READ_EN: each read also fetches the following word into data_rd_2.
module sram_controller #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  Bus_if.slave        bus,
  output logic [19:0] sram_addr,
  inout  wire  [31:0] sram_data,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n
);

  localparam int CW = 16;
  localparam logic [CW-1:0] READ_LAST  = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WRITE_LAST = CW'(WRITE_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
`ifdef SRAM_DUAL_READ_EN
    READ2,
`endif
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [19:0]     addr_reg, addr_next;
  logic [31:0]     wdata_reg, wdata_next;
  logic [3:0]      be_n_reg, be_n_next;
  logic            ce_n_reg, ce_n_next;
  logic            oe_n_reg, oe_n_next;
  logic            we_n_reg, we_n_next;
  logic            drive_reg, drive_next;
  logic [31:0]     data_rd_reg, data_rd_next;
  logic [31:0]     data_rd_2_reg, data_rd_2_next;
  logic            read_last, write_last;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{bus.address[31:22], bus.address[1:0]};
  assign read_last  = (cnt_reg == READ_LAST);
  assign write_last = (cnt_reg == WRITE_LAST);

  // State register plus all registered SRAM-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_n_reg      <= 4'hF;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      drive_reg     <= 1'b0;
      data_rd_reg   <= '0;
      data_rd_2_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      be_n_reg      <= be_n_next;
      ce_n_reg      <= ce_n_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      drive_reg     <= drive_next;
      data_rd_reg   <= data_rd_next;
      data_rd_2_reg <= data_rd_2_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // write wins when both strobes are asserted
        if (bus.write)     state_next = WR_SETUP;
        else if (bus.read) state_next = READ;
      end
      READ: begin
`ifdef SRAM_DUAL_READ_EN
        if (read_last) state_next = READ2;
`else
        if (read_last) state_next = DONE;
`endif
      end
`ifdef SRAM_DUAL_READ_EN
      READ2:    if (read_last) state_next = DONE;
`endif
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: if (write_last) state_next = WR_HOLD;
      WR_HOLD:  state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Control outputs are decoded from the state being entered, then registered
  always_comb begin
    cnt_next       = '0;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    data_rd_next   = data_rd_reg;
    data_rd_2_next = data_rd_2_reg;
    ce_n_next      = 1'b1;
    oe_n_next      = 1'b1;
    we_n_next      = 1'b1;
    drive_next     = 1'b0;
    be_n_next      = 4'hF;

    if (state_next == state_reg && state_reg != IDLE && state_reg != DONE)
      cnt_next = cnt_reg + 1'b1;

    if (state_reg == IDLE && state_next != IDLE) begin
      addr_next  = bus.address[21:2];
      wdata_next = bus.data_wr;
    end

    if (state_reg == READ && read_last)
      data_rd_next = sram_data;
`ifdef SRAM_DUAL_READ_EN
    if (state_reg == READ && state_next == READ2)
      addr_next = addr_reg + 1'b1;
    if (state_reg == READ2 && read_last)
      data_rd_2_next = sram_data;
`endif

    case (state_next)
      READ: begin
        ce_n_next = 1'b0;
        oe_n_next = 1'b0;
        be_n_next = 4'h0;
      end
`ifdef SRAM_DUAL_READ_EN
      READ2: begin
        ce_n_next = 1'b0;
        oe_n_next = 1'b0;
        be_n_next = 4'h0;
      end
`endif
      WR_SETUP: begin
        ce_n_next  = 1'b0;
        drive_next = 1'b1;
        be_n_next  = ~bus.mask;
      end
      WR_PULSE: begin
        ce_n_next  = 1'b0;
        we_n_next  = 1'b0;
        drive_next = 1'b1;
        be_n_next  = be_n_reg;
      end
      WR_HOLD: begin
        ce_n_next  = 1'b0;
        drive_next = 1'b1;
        be_n_next  = be_n_reg;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_reg)
      IDLE:    bus.stall = bus.read | bus.write;
      DONE:    bus.stall = 1'b0;
      default: bus.stall = 1'b1;
    endcase
  end

  assign sram_addr     = addr_reg;
  assign sram_ce_n     = ce_n_reg;
  assign sram_oe_n     = oe_n_reg;
  assign sram_we_n     = we_n_reg;
  assign sram_be_n     = be_n_reg;
  assign sram_data     = drive_reg ? wdata_reg : 32'bz;
  assign bus.data_rd   = data_rd_reg;
`ifdef SRAM_DUAL_READ_EN
  assign bus.data_rd_2 = data_rd_2_reg;
`else
  assign bus.data_rd_2 = 32'h0;
  logic unused_rd_2;
  assign unused_rd_2 = ^data_rd_2_reg;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller against a behavioural asynchronous SRAM.
module tb_sram_controller;
  localparam int RW = 2;
  localparam int WW = 1;
`ifdef SRAM_DUAL_READ_EN
  localparam int RD_LAT = 2 * RW + 1;
  localparam int RD_CE  = 2 * RW;
`else
  localparam int RD_LAT = RW + 1;
  localparam int RD_CE  = RW;
`endif
  localparam int WR_LAT = WW + 3;
  localparam int WR_CE  = WW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  Bus_if bus_i();
  logic [19:0] sram_addr;
  wire  [31:0] sram_data;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  sram_controller #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_i.slave),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  // Behavioural SRAM
  logic [31:0] mem [0:1048575];
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 32'bz;

  logic [19:0] wa;
  logic [31:0] wd;
  logic [3:0]  wb;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge sram_we_n) begin
    wa = sram_addr; wd = sram_data; wb = sram_be_n;
  end

  always @(posedge sram_we_n) begin
    if (rst_n && !sram_ce_n) begin
      chk("we_addr_stable", {12'h0, sram_addr}, {12'h0, wa});
      chk("we_data_stable", sram_data, wd);
      chk("we_be_stable", {28'h0, sram_be_n}, {28'h0, wb});
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) mem[sram_addr][8*b +: 8] = sram_data[8*b +: 8];
    end
  end

  typedef struct {
    logic [31:0] rd;
    logic [31:0] rd2;
    int          lat;
    int          ce_low;
    int          oe_low;
    int          we_low;
    logic [19:0] addr;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(input logic [31:0] rd, rd2, input int lat, ce, oe, we,
                              input logic [19:0] addr, input logic [3:0] be);
    exp_t e;
    e.rd = rd; e.rd2 = rd2; e.lat = lat; e.ce_low = ce; e.oe_low = oe;
    e.we_low = we; e.addr = addr; e.be = be;
    return e;
  endfunction

  function automatic logic [31:0] d2(input logic [31:0] v);
`ifdef SRAM_DUAL_READ_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Monitor: pops one expectation per completed access (stall low with request held)
  int lat_c = 0, ce_c = 0, oe_c = 0, we_c = 0;
  logic [19:0] a_seen = '0;
  logic [3:0]  be_seen = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      lat_c = 0; ce_c = 0; oe_c = 0; we_c = 0;
    end else if (bus_i.read || bus_i.write) begin
      if (bus_i.stall) begin
        lat_c++;
        if (!sram_ce_n) begin
          if (ce_c == 0) begin a_seen = sram_addr; be_seen = sram_be_n; end
          ce_c++;
        end
        if (!sram_oe_n) oe_c++;
        if (!sram_we_n) we_c++;
      end else begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL scoreboard: completion with empty queue at %0t", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data_rd", bus_i.data_rd, e.rd);
          chk("data_rd_2", bus_i.data_rd_2, e.rd2);
          chk("stall_cycles", 32'(lat_c), 32'(e.lat));
          chk("ce_low_cycles", 32'(ce_c), 32'(e.ce_low));
          chk("oe_low_cycles", 32'(oe_c), 32'(e.oe_low));
          chk("we_low_cycles", 32'(we_c), 32'(e.we_low));
          chk("sram_addr", {12'h0, a_seen}, {12'h0, e.addr});
          chk("sram_be_n", {28'h0, be_seen}, {28'h0, e.be});
          $display("txn addr=%h rd=%h rd2=%h stall=%0d ce=%0d we=%0d", a_seen,
                   bus_i.data_rd, bus_i.data_rd_2, lat_c, ce_c, we_c);
        end
        lat_c = 0; ce_c = 0; oe_c = 0; we_c = 0;
      end
    end
  end

  task automatic finish_now();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Drive a request from the cycle after the current edge; return at the negedge of DONE
  task automatic do_req(input logic rd, wr, input logic [31:0] addr, data,
                        input logic [3:0] mask, input exp_t e);
    bit done = 0;
    q.push_back(e);
    @(posedge clk); #1;
    bus_i.read = rd; bus_i.write = wr; bus_i.address = addr;
    bus_i.data_wr = data; bus_i.mask = mask;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!bus_i.stall) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: stall never dropped for addr %h", addr);
      finish_now();
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    bus_i.read = 0; bus_i.write = 0;
  endtask

  initial begin
    int we_seen;
    bit got_we;
    bus_i.read = 0; bus_i.write = 0; bus_i.address = '0;
    bus_i.data_wr = '0; bus_i.mask = '0;
    for (int i = 0; i < 1048576; i++) mem[i] = 32'h0;
    mem[20'h12345] = 32'hDEADBEEF;
    mem[20'h12346] = 32'h600DCAFE;
    mem[20'h00004] = 32'h01234567;
    mem[20'hFFFFF] = 32'hCAFEF00D;
    mem[20'h00000] = 32'h13579BDF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'h0, bus_i.stall}, 32'h0);
    chk("rst_ce_n", {31'h0, sram_ce_n}, 32'h1);
    chk("rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
    chk("rst_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("rst_be_n", {28'h0, sram_be_n}, 32'hF);
    chk("rst_addr", {12'h0, sram_addr}, 32'h0);
    chk("rst_data_rd", bus_i.data_rd, 32'h0);
    chk("rst_data_rd_2", bus_i.data_rd_2, 32'h0);
    @(negedge clk); rst_n = 1;

    do_req(1, 0, 32'h0004_8D14, 32'h0, 4'h0,
           mk(32'hDEADBEEF, d2(32'h600DCAFE), RD_LAT, RD_CE, RD_CE, 0, 20'h12345, 4'h0));
    go_idle();
    do_req(0, 1, 32'h0000_0010, 32'hA5A5A5A5, 4'b0010,
           mk(32'hDEADBEEF, d2(32'h600DCAFE), WR_LAT, WR_CE, 0, WW, 20'h00004, 4'b1101));
    go_idle();
    do_req(1, 0, 32'h0000_0010, 32'h0, 4'h0,
           mk(32'h0123A567, 32'h0, RD_LAT, RD_CE, RD_CE, 0, 20'h00004, 4'h0));
    go_idle();
    // back-to-back: write then read with a single IDLE cycle between
    do_req(0, 1, 32'h0000_0020, 32'h11111111, 4'hF,
           mk(32'h0123A567, 32'h0, WR_LAT, WR_CE, 0, WW, 20'h00008, 4'h0));
    do_req(1, 0, 32'h0000_0020, 32'h0, 4'h0,
           mk(32'h11111111, 32'h0, RD_LAT, RD_CE, RD_CE, 0, 20'h00008, 4'h0));
    // read and write together is a write
    do_req(1, 1, 32'h0000_0030, 32'h0BADF00D, 4'hF,
           mk(32'h11111111, 32'h0, WR_LAT, WR_CE, 0, WW, 20'h0000C, 4'h0));
    do_req(1, 0, 32'h0000_0030, 32'h0, 4'h0,
           mk(32'h0BADF00D, 32'h0, RD_LAT, RD_CE, RD_CE, 0, 20'h0000C, 4'h0));
    go_idle();
    // upper and byte-offset address bits are ignored
    do_req(1, 0, 32'hFFC0_0033, 32'h0, 4'h0,
           mk(32'h0BADF00D, 32'h0, RD_LAT, RD_CE, RD_CE, 0, 20'h0000C, 4'h0));
    go_idle();
    // top word: second word wraps to 0 when dual read is enabled
    do_req(1, 0, 32'h003F_FFFC, 32'h0, 4'h0,
           mk(32'hCAFEF00D, d2(32'h13579BDF), RD_LAT, RD_CE, RD_CE, 0, 20'hFFFFF, 4'h0));
    go_idle();

    // reset asserted while WE_n is low
    @(posedge clk); #1;
    bus_i.write = 1; bus_i.address = 32'h0000_0040; bus_i.data_wr = 32'h77777777; bus_i.mask = 4'hF;
    got_we = 0;
    for (int i = 0; i < 10 && !got_we; i++) begin
      @(negedge clk);
      if (!sram_we_n) got_we = 1;
    end
    chk("reached_wr_pulse", {31'h0, got_we}, 32'h1);
    #2 rst_n = 0;
    #1;
    chk("async_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("async_ce_n", {31'h0, sram_ce_n}, 32'h1);
    chk("async_data_rd", bus_i.data_rd, 32'h0);
    chk("async_data_rd_2", bus_i.data_rd_2, 32'h0);
    bus_i.write = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!sram_we_n || !sram_ce_n) we_seen++;
    end
    chk("no_pulse_after_reset", 32'(we_seen), 32'h0);
    chk("idle_stall_after_reset", {31'h0, bus_i.stall}, 32'h0);

    do_req(1, 0, 32'h0000_0030, 32'h0, 4'h0,
           mk(32'h0BADF00D, 32'h0, RD_LAT, RD_CE, RD_CE, 0, 20'h0000C, 4'h0));
    go_idle();

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    finish_now();
  end

endmodule
